// File: rtl/datapath_pkg.sv
// Shared constants for the register/ALU datapath: register control codes, ALU ops
// and the instruction opcodes that the decoder turns into Tx/Ty/Tz codes.
package datapath_pkg;

    localparam logic [1:0] T_HOLD = 2'b00;
    localparam logic [1:0] T_LOAD = 2'b01;
    localparam logic [1:0] T_SHR  = 2'b10;
    localparam logic [1:0] T_CLR  = 2'b11;

    localparam logic ULA_ADD = 1'b0;
    localparam logic ULA_SUB = 1'b1;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_CLRLD = 3'd1,
        OP_ADDLD = 3'd2,
        OP_ADD   = 3'd3,
        OP_DIV2  = 3'd4,
        OP_DISP  = 3'd5
    } opcode_t;

    typedef struct packed {
        logic [1:0] tx;
        logic [1:0] ty;
        logic [1:0] tz;
    } ctrl_t;

    // Register control codes the decoder emits for each instruction.
    function automatic ctrl_t op_ctrl(input opcode_t op);
        ctrl_t c;
        c = '{T_HOLD, T_HOLD, T_HOLD};
        case (op)
            OP_CLRLD: c = '{T_LOAD, T_CLR,  T_CLR};
            OP_ADDLD: c = '{T_LOAD, T_LOAD, T_HOLD};
            OP_ADD:   c = '{T_HOLD, T_LOAD, T_HOLD};
            OP_DIV2:  c = '{T_HOLD, T_SHR,  T_HOLD};
            OP_DISP:  c = '{T_CLR,  T_CLR,  T_LOAD};
            default:  c = '{T_HOLD, T_HOLD, T_HOLD};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_xyz_ctrl_reg.sv
// N-bit working register driven by a 2-bit control code: hold, load, shift right, clear.
module ctrl_reg
    import datapath_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   code,
    input  logic [N-1:0] load_data,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            case (code)
                T_HOLD:  q <= q;
                T_LOAD:  q <= load_data;
                T_SHR:   q <= {1'b0, q[N-1:1]};
                default: q <= '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath with add/subtract ALU; Y accumulates, Z feeds the display.
module datapath_xyz
    import datapath_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] Entrada,
    input  logic [1:0]   Tx,
    input  logic [1:0]   Ty,
    input  logic [1:0]   Tz,
    input  logic         Tula,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic [N-1:0] Z,
    output logic [N-1:0] ula_out,
    output logic         carry,
    output logic         z_valid
);

    logic [N:0] alu_full;

    // Extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        if (Tula == ULA_SUB) alu_full = {1'b0, Y} - {1'b0, X};
        else                 alu_full = {1'b0, Y} + {1'b0, X};
    end

    assign ula_out = alu_full[N-1:0];

    ctrl_reg #(.N(N)) u_x (
        .clk(clk), .rst_n(rst_n), .en(en), .code(Tx), .load_data(Entrada), .q(X)
    );

    ctrl_reg #(.N(N)) u_y (
        .clk(clk), .rst_n(rst_n), .en(en), .code(Ty), .load_data(ula_out), .q(Y)
    );

    ctrl_reg #(.N(N)) u_z (
        .clk(clk), .rst_n(rst_n), .en(en), .code(Tz), .load_data(Y), .q(Z)
    );

    // carry tracks the last ALU write into Y; a shift of Y leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry   <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            z_valid <= en && (Tz == T_LOAD);
            if (en) begin
                if (Ty == T_LOAD)     carry <= alu_full[N];
                else if (Ty == T_CLR) carry <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_datapath_xyz.sv
// Directed bench for datapath_xyz with hand-computed register, carry and z_valid values.
module tb_datapath_xyz;
    import datapath_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] entrada;
    logic [1:0] tx, ty, tz;
    logic       tula;
    logic [3:0] x, y, z, ula_out;
    logic       carry, z_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_xyz #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .Entrada(entrada),
        .Tx(tx), .Ty(ty), .Tz(tz), .Tula(tula),
        .X(x), .Y(y), .Z(z), .ula_out(ula_out),
        .carry(carry), .z_valid(z_valid)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] cx, input logic [1:0] cy,
                        input logic [1:0] cz, input logic op, input logic [3:0] d);
        en = e; tx = cx; ty = cy; tz = cz; tula = op; entrada = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_op(input opcode_t o, input logic op, input logic [3:0] d);
        ctrl_t c;
        c = op_ctrl(o);
        step(1'b1, c.tx, c.ty, c.tz, op, d);
    endtask

    task automatic chk_regs(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                            input logic [3:0] ez, input logic ec, input logic ev);
        chk({tag, ".X"}, 8'(x), 8'(ex));
        chk({tag, ".Y"}, 8'(y), 8'(ey));
        chk({tag, ".Z"}, 8'(z), 8'(ez));
        chk({tag, ".carry"}, 8'(carry), 8'(ec));
        chk({tag, ".z_valid"}, 8'(z_valid), 8'(ev));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; entrada = '0;
        tx = T_HOLD; ty = T_HOLD; tz = T_HOLD; tula = ULA_ADD;
        #12;
        chk_regs("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Program sequence
        step_op(OP_CLRLD, ULA_ADD, 4'd5);
        chk_regs("clrld", 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        step_op(OP_ADDLD, ULA_ADD, 4'd3);
        chk_regs("addld", 4'd3, 4'd5, 4'd0, 1'b0, 1'b0);
        chk("ula_comb", 8'(ula_out), 8'd8);
        step_op(OP_ADD, ULA_ADD, 4'd0);
        chk_regs("add", 4'd3, 4'd8, 4'd0, 1'b0, 1'b0);
        step_op(OP_DIV2, ULA_ADD, 4'd0);
        chk_regs("div2", 4'd3, 4'd4, 4'd0, 1'b0, 1'b0);
        step_op(OP_DISP, ULA_ADD, 4'd0);
        chk_regs("disp", 4'd0, 4'd0, 4'd4, 1'b0, 1'b1);
        step(1'b1, T_HOLD, T_HOLD, T_HOLD, ULA_ADD, 4'd0);
        chk_regs("disp_after", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);

        // Overflow on add, then shift keeps carry
        step(1'b1, T_LOAD, T_HOLD, T_HOLD, ULA_ADD, 4'd9);
        step(1'b1, T_HOLD, T_LOAD, T_HOLD, ULA_ADD, 4'd0);
        chk_regs("y_eq_9", 4'd9, 4'd9, 4'd4, 1'b0, 1'b0);
        chk("ula_ovf_comb", 8'(ula_out), 8'd2);
        step_op(OP_ADD, ULA_ADD, 4'd0);
        chk_regs("ovf_add", 4'd9, 4'd2, 4'd4, 1'b1, 1'b0);
        step_op(OP_DIV2, ULA_ADD, 4'd0);
        chk_regs("ovf_div2", 4'd9, 4'd1, 4'd4, 1'b1, 1'b0);

        // Subtract without borrow: X=3, Y=5
        step(1'b1, T_LOAD, T_CLR, T_HOLD, ULA_ADD, 4'd5);
        chk_regs("clr_carry", 4'd5, 4'd0, 4'd4, 1'b0, 1'b0);
        step(1'b1, T_LOAD, T_LOAD, T_HOLD, ULA_ADD, 4'd3);
        chk_regs("simul_xy", 4'd3, 4'd5, 4'd4, 1'b0, 1'b0);
        step(1'b1, T_HOLD, T_LOAD, T_HOLD, ULA_SUB, 4'd0);
        chk_regs("sub_5_3", 4'd3, 4'd2, 4'd4, 1'b0, 1'b0);

        // Subtract with borrow: X=5, Y=3
        step(1'b1, T_LOAD, T_CLR, T_HOLD, ULA_ADD, 4'd3);
        step(1'b1, T_LOAD, T_LOAD, T_HOLD, ULA_ADD, 4'd5);
        chk_regs("pre_sub", 4'd5, 4'd3, 4'd4, 1'b0, 1'b0);
        chk("ula_sub_comb", 8'(ula_out), 8'd8);
        tula = ULA_SUB;
        #1;
        chk("ula_sub_comb2", 8'(ula_out), 8'd14);
        step(1'b1, T_HOLD, T_LOAD, T_HOLD, ULA_SUB, 4'd0);
        chk_regs("sub_3_5", 4'd5, 4'd14, 4'd4, 1'b1, 1'b0);

        // Enable gating
        for (int i = 0; i < 3; i++) begin
            step(1'b0, T_LOAD, T_CLR, T_CLR, ULA_ADD, 4'd9);
            chk_regs("en0_clrld", 4'd5, 4'd14, 4'd4, 1'b1, 1'b0);
        end
        step(1'b0, T_CLR, T_CLR, T_LOAD, ULA_ADD, 4'd9);
        chk_regs("en0_disp", 4'd5, 4'd14, 4'd4, 1'b1, 1'b0);
        step_op(OP_CLRLD, ULA_ADD, 4'd9);
        chk_regs("en1_clrld", 4'd9, 4'd0, 4'd0, 1'b0, 1'b0);

        // Simultaneous Z load and Y clear; build Y=6 via a borrowing subtract
        step(1'b1, T_LOAD, T_HOLD, T_HOLD, ULA_ADD, 4'd10);
        step(1'b1, T_HOLD, T_LOAD, T_HOLD, ULA_SUB, 4'd0);
        chk_regs("y_eq_6", 4'd10, 4'd6, 4'd0, 1'b1, 1'b0);
        step(1'b1, T_HOLD, T_CLR, T_LOAD, ULA_ADD, 4'd0);
        chk_regs("z_ld_y_clr", 4'd10, 4'd0, 4'd6, 1'b0, 1'b1);
        step(1'b1, T_HOLD, T_HOLD, T_LOAD, ULA_ADD, 4'd0);
        chk_regs("z_b2b", 4'd10, 4'd0, 4'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with X=7 and z_valid high
        step(1'b1, T_LOAD, T_LOAD, T_LOAD, ULA_ADD, 4'd7);
        chk_regs("pre_rst", 4'd7, 4'd10, 4'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("async_rst", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step_op(OP_CLRLD, ULA_ADD, 4'd2);
        chk_regs("post_rst", 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
